// File: rtl/float_sum_accumulator.sv
// Streaming single-precision accumulator for the SoftMax denominator.
// One truncating float add per accepted element; sum is final when done=1.
module float_sum_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  done
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]         count, count_nx;
    logic                  done_r, done_nx;
    logic                  accept;

    // Truncating adder: larger magnitude first, smaller aligned by shift.
    function automatic logic [31:0] fadd(
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [31:0] a, b, r;
        logic [7:0]  ea, eb, sh;
        logic [23:0] ma, mb, d;
        logic [24:0] s;
        logic [4:0]  lz;
        if (y[30:0] > x[30:0]) begin
            a = y;
            b = x;
        end else begin
            a = x;
            b = y;
        end
        ea = a[30:23];
        eb = b[30:23];
        sh = ea - eb;
        ma = {1'b1, a[22:0]};
        mb = (sh > 8'd23) ? 24'd0 : ({1'b1, b[22:0]} >> sh);
        s  = '0;
        d  = '0;
        lz = '0;
        r  = '0;
        if (eb == 8'd0) begin
            r = a;
        end else if (a[31] == b[31]) begin
            s = {1'b0, ma} + {1'b0, mb};
            if (s[24])
                r = {a[31], ea + 8'd1, s[23:1]};
            else
                r = {a[31], ea, s[22:0]};
        end else begin
            d = ma - mb;
            if (d != 24'd0) begin
                for (int i = 0; i < 24; i++)
                    if (d[i]) lz = 5'(23 - i);
                d = d << lz;
                r = {a[31], ea - {3'b000, lz}, d[22:0]};
            end
        end
        return r;
    endfunction

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    assign sum      = acc;
    assign done     = done_r;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        done_nx  = done_r;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    count_nx = '0;
                    done_nx  = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nx   = fadd(acc, in_data);
                    count_nx = count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            count  <= count_nx;
            done_r <= done_nx;
        end
    end

endmodule
